// File: rtl/regfile_wb_arbiter.sv
// Purpose : shares the register-file write port between the in-order WB stage
//           and buffered multiply/divide results, and tracks pending MDU
//           destinations.
// Latency : an MDU result accepted in cycle N reaches the write port no
//           earlier than N+1. A WB write reaches the port in its own cycle
//           unless the block is in FORCE.
// Backpr. : mdu_ready = !full, independent of a same-cycle pop. pipe_stall is
//           held high for the one cycle in which a forced drain takes the port.
//
// Ports:
//   clk, rst                         clock and synchronous active-high reset
//   pipe_wb_valid/pipe_rd/pipe_wb_data  WB stage register write (rd 0 = none)
//   pipe_stall                       hold the WB stage this cycle
//   mdu_issue/mdu_issue_rd           MDU op issued; marks rd pending
//   mdu_valid/mdu_ready/mdu_rd/mdu_data  MDU result handshake
//   RegWrite/rd/write_data           register-file write port
//   pending                          bit i set: xi awaits an MDU result
module regfile_wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wb_valid,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wb_data,
  output logic            pipe_stall,
  input  logic            mdu_issue,
  input  logic [4:0]      mdu_issue_rd,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            RegWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic [31:0]     pending
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Result buffer: circular storage, pointers wrap naturally (power-of-two
  // depth), occupancy count separates full from empty.
  // ---------------------------------------------------------------------------
  logic [4:0]      fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  logic [SW-1:0]   starve_cnt;
  logic [SW-1:0]   starve_nxt;
  logic [31:0]     pending_nxt;

  logic            pipe_real;
  logic            head_win;
  logic            pipe_win;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign mdu_ready = !full;
  assign push      = mdu_valid && !full;
  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // A WB write to x0 is not a write at all and leaves the slot free.
  assign pipe_real = pipe_wb_valid && (pipe_rd != 5'd0);

  // ---------------------------------------------------------------------------
  // Arbitration: a forced drain beats the pipe, the pipe beats the buffer.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_win = 1'b0;
    pipe_win = 1'b0;
    if (state == FORCE) begin
      head_win = !empty;
    end else if (pipe_real) begin
      pipe_win = 1'b1;
    end else if (!empty) begin
      head_win = 1'b1;
    end
  end

  assign pop       = head_win;
  assign count_nxt = count + CW'(push) - CW'(pop);

  // Write port. Results destined for x0 still pop, but never assert RegWrite.
  always_comb begin
    RegWrite   = 1'b0;
    rd         = 5'd0;
    write_data = '0;
    if (!rst) begin
      if (head_win) begin
        RegWrite   = (head_rd != 5'd0);
        rd         = head_rd;
        write_data = head_data;
      end else if (pipe_win) begin
        RegWrite   = 1'b1;
        rd         = pipe_rd;
        write_data = pipe_wb_data;
      end
    end
  end

  // Stall is a decode of the registered state, so it is glitch-free and known
  // at the start of the cycle.
  assign pipe_stall = (state == FORCE);

  // ---------------------------------------------------------------------------
  // Starvation FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        starve_nxt = '0;
        if (push) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (pop) begin
          starve_nxt = '0;
          if (count_nxt == '0) begin
            state_nxt = IDLE;
          end
        end else if (pipe_win && !empty) begin
          // The increment that would reach the limit goes straight to FORCE;
          // the stored count therefore never exceeds STARVE_LIMIT-1.
          if ((starve_cnt + SW'(1)) == SW'(STARVE_LIMIT)) begin
            state_nxt  = FORCE;
            starve_nxt = '0;
          end else begin
            starve_nxt = starve_cnt + SW'(1);
          end
        end
      end
      FORCE: begin
        starve_nxt = '0;
        state_nxt  = (count_nxt != '0) ? WAIT : IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        starve_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending scoreboard: a same-cycle issue to the retiring register wins, so
  // the set is applied after the clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_nxt = pending;
    if (pop && (head_rd != 5'd0)) begin
      pending_nxt[head_rd] = 1'b0;
    end
    if (mdu_issue && (mdu_issue_rd != 5'd0)) begin
      pending_nxt[mdu_issue_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pending    <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      count      <= count_nxt;
      pending    <= pending_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_rd[wr_ptr]   <= mdu_rd;
      fifo_data[wr_ptr] <= mdu_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [31:0] pending;

  int passed = 0;
  int total  = 0;

  regfile_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_valid(pipe_wb_valid), .pipe_rd(pipe_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_stall(pipe_stall),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .RegWrite(RegWrite), .rd(rd), .write_data(write_data), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Each cycle: step() to just after the edge, drive, sample() at negedge, check.
  task automatic step();
    @(posedge clk);
    #1;
    mdu_issue    = 1'b0;
    mdu_issue_rd = 5'd0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_pipe(input logic v, input logic [4:0] r, input logic [31:0] d);
    pipe_wb_valid = v;
    pipe_rd       = r;
    pipe_wb_data  = d;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
    mdu_valid = v;
    mdu_rd    = r;
    mdu_data  = d;
  endtask

  // Issuing to a register that is still pending is a protocol violation.
  task automatic issue(input logic [4:0] r);
    chk("issue_legal", {31'd0, pending[r]}, 32'd0);
    mdu_issue    = 1'b1;
    mdu_issue_rd = r;
  endtask

  initial begin
    rst = 1'b1;
    mdu_issue = 1'b0; mdu_issue_rd = 5'd0;
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);

    // ---- reset ----
    step(); drive_pipe(1'b1, 5'd3, 32'hAAAA); sample();
    chk("rst_regwrite", RegWrite, 0);
    step(); rst = 1'b0; drive_pipe(1'b0, 5'd0, 32'd0); sample();
    chk("rst_stall", pipe_stall, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", mdu_ready, 1);
    chk("rst_nowrite", RegWrite, 0);

    // ---- idle drain ----
    step(); issue(5'd5); sample();
    chk("pend_reg_lat", pending, 0);
    step(); sample();
    chk("pend5_set", pending, 32'h20);
    step(); drive_mdu(1'b1, 5'd5, 32'h1234); sample();
    chk("drain_ready", mdu_ready, 1);
    chk("no_bypass", RegWrite, 0);
    step(); drive_mdu(1'b0, 5'd0, 32'd0); sample();
    chk("drain_we", RegWrite, 1);
    chk("drain_rd", rd, 5);
    chk("drain_data", write_data, 32'h1234);
    chk("drain_pend_held", pending, 32'h20);
    step(); sample();
    chk("drain_pend_clr", pending, 0);
    chk("drain_idle", RegWrite, 0);

    // ---- starvation: accepted at N, blocked N+1..N+4, forced at N+5 ----
    step(); drive_pipe(1'b1, 5'd1, 32'h101); issue(5'd7); sample();
    chk("starve_c0_rd", rd, 1);
    step(); drive_pipe(1'b1, 5'd2, 32'h102); drive_mdu(1'b1, 5'd7, 32'h7777); sample();
    chk("starve_acc_ready", mdu_ready, 1);
    chk("starve_acc_rd", rd, 2);
    for (int k = 3; k <= 6; k++) begin
      step(); drive_mdu(1'b0, 5'd0, 32'd0);
      drive_pipe(1'b1, 5'(k), 32'h100 + k); sample();
      chk("starve_blk_stall", pipe_stall, 0);
      chk("starve_blk_rd", rd, k);
      chk("starve_blk_pend", pending, 32'h80);
    end
    step(); drive_pipe(1'b1, 5'd7, 32'h107); sample();
    chk("force_stall", pipe_stall, 1);
    chk("force_we", RegWrite, 1);
    chk("force_rd", rd, 7);
    chk("force_data", write_data, 32'h7777);
    step(); sample();
    chk("held_stall", pipe_stall, 0);
    chk("held_rd", rd, 7);
    chk("held_data", write_data, 32'h107);
    chk("held_pend", pending, 0);
    step(); drive_pipe(1'b1, 5'd8, 32'h108); sample();
    chk("after_rd8", rd, 8);
    step(); drive_pipe(1'b1, 5'd9, 32'h109); sample();
    chk("after_data9", write_data, 32'h109);

    // ---- backpressure ----
    step(); drive_pipe(1'b1, 5'd1, 32'h201); issue(5'd10); sample();
    step(); drive_pipe(1'b1, 5'd2, 32'h202); issue(5'd11); sample();
    step(); drive_pipe(1'b1, 5'd3, 32'h203); issue(5'd12); sample();
    step(); drive_pipe(1'b1, 5'd4, 32'h204); drive_mdu(1'b1, 5'd10, 32'hA0); sample();
    chk("bp_pend", pending, 32'h1C00);
    chk("bp_ready0", mdu_ready, 1);
    step(); drive_pipe(1'b1, 5'd5, 32'h205); drive_mdu(1'b1, 5'd11, 32'hB0); sample();
    chk("bp_ready1", mdu_ready, 1);
    chk("bp_rd5", rd, 5);
    step(); drive_pipe(1'b1, 5'd6, 32'h206); drive_mdu(1'b1, 5'd12, 32'hC0); sample();
    chk("bp_full2", mdu_ready, 0);
    step(); drive_pipe(1'b1, 5'd7, 32'h207); sample();
    chk("bp_full3", mdu_ready, 0);
    chk("bp_nostall3", pipe_stall, 0);
    step(); drive_pipe(1'b1, 5'd8, 32'h208); sample();
    chk("bp_nostall4", pipe_stall, 0);
    chk("bp_rd8", rd, 8);
    step(); drive_pipe(1'b1, 5'd9, 32'h209); sample();
    chk("bp_force_stall", pipe_stall, 1);
    chk("bp_force_rd", rd, 10);
    chk("bp_force_data", write_data, 32'hA0);
    chk("bp_force_ready", mdu_ready, 0);
    step(); sample();
    chk("bp_third_ready", mdu_ready, 1);
    chk("bp_third_stall", pipe_stall, 0);
    chk("bp_held_data", write_data, 32'h209);
    step(); drive_pipe(1'b0, 5'd0, 32'd0); drive_mdu(1'b0, 5'd0, 32'd0); sample();
    chk("bp_drain11_rd", rd, 11);
    chk("bp_drain11_data", write_data, 32'hB0);
    step(); sample();
    chk("bp_drain12_rd", rd, 12);
    chk("bp_drain12_data", write_data, 32'hC0);
    step(); sample();
    chk("bp_done_we", RegWrite, 0);
    chk("bp_done_pend", pending, 0);

    // ---- x0 slots ----
    step(); issue(5'd3); sample();
    step(); drive_pipe(1'b1, 5'd6, 32'h306); drive_mdu(1'b1, 5'd3, 32'h33); sample();
    chk("x0_pipe_rd6", rd, 6);
    step(); drive_pipe(1'b1, 5'd0, 32'hDEAD); drive_mdu(1'b0, 5'd0, 32'd0); sample();
    chk("x0_slot_we", RegWrite, 1);
    chk("x0_slot_rd", rd, 3);
    chk("x0_slot_data", write_data, 32'h33);
    step(); drive_pipe(1'b0, 5'd0, 32'd0); sample();
    chk("x0_slot_pend", pending, 0);
    chk("x0_slot_idle", RegWrite, 0);
    step(); issue(5'd8); sample();
    step(); drive_mdu(1'b1, 5'd0, 32'h55); sample();
    step(); drive_mdu(1'b1, 5'd8, 32'h88); sample();
    chk("mdu_x0_we", RegWrite, 0);
    chk("mdu_x0_pend", pending, 32'h100);
    step(); drive_mdu(1'b0, 5'd0, 32'd0); sample();
    chk("mdu_x0_popped_rd", rd, 8);
    chk("mdu_x0_popped_data", write_data, 32'h88);
    step(); sample();
    chk("mdu_x0_pend_clr", pending, 0);

    // ---- same-cycle set/clear ----
    step(); issue(5'd4); sample();
    step(); drive_mdu(1'b1, 5'd4, 32'h44); sample();
    step(); drive_mdu(1'b0, 5'd0, 32'd0); mdu_issue = 1'b1; mdu_issue_rd = 5'd4; sample();
    chk("setclr_rd", rd, 4);
    chk("setclr_data", write_data, 32'h44);
    step(); sample();
    chk("setclr_pend", pending, 32'h10);

    // ---- reset mid-operation ----
    step(); issue(5'd5); sample();
    step(); drive_pipe(1'b1, 5'd1, 32'h401); drive_mdu(1'b1, 5'd4, 32'h4A); sample();
    chk("midrst_pend", pending, 32'h30);
    step(); drive_pipe(1'b1, 5'd2, 32'h402); drive_mdu(1'b1, 5'd5, 32'h5A); sample();
    chk("midrst_ready1", mdu_ready, 1);
    step(); drive_pipe(1'b1, 5'd3, 32'h403); drive_mdu(1'b1, 5'd6, 32'h6A); rst = 1'b1; sample();
    chk("midrst_full", mdu_ready, 0);
    chk("midrst_we_in_rst", RegWrite, 0);
    step(); rst = 1'b0; drive_pipe(1'b0, 5'd0, 32'd0); drive_mdu(1'b0, 5'd0, 32'd0); sample();
    chk("midrst_pend_clr", pending, 0);
    chk("midrst_ready", mdu_ready, 1);
    chk("midrst_stall", pipe_stall, 0);
    chk("midrst_nowrite", RegWrite, 0);
    step(); sample();
    chk("midrst_noghost", RegWrite, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
